// File: rtl/operand_fetch_stage_pkg.sv
// Shared widths and the held operand-entry layout for the operand fetch stage.
package operand_fetch_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // One entry as presented to execute, plus the source fields kept for refresh.
    typedef struct packed {
        logic [DATA_W_DEF-1:0] a;
        logic [DATA_W_DEF-1:0] b;
        logic [ADDR_W_DEF-1:0] da;
        logic                  rw;
        logic [ADDR_W_DEF-1:0] aa;
        logic [ADDR_W_DEF-1:0] ba;
        logic                  mb;
    } operand_entry_t;

endpackage

// File: rtl/operand_fetch_stage_bypass_mux.sv
// Selects the writeback value over register-file data when the write targets addr.
module operand_bypass_mux #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] rf_data_i,
    input  logic              wb_rw_i,
    input  logic [ADDR_W-1:0] wb_da_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic [DATA_W-1:0] data_o
);

    // Register 0 is writable, so no zero-address exception.
    always_comb begin
        data_o = (wb_rw_i && (wb_da_i == addr_i)) ? wb_data_i : rf_data_i;
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: drives register-file read ports, registers an operand
// pair for execute under valid/ready, and keeps a stalled entry coherent with
// writeback. Build option OPERAND_BYPASS_EN: forward writeback at capture;
// otherwise the stage stalls one cycle on a writeback hazard.
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_aa,
    input  logic [ADDR_W-1:0] in_ba,
    input  logic [ADDR_W-1:0] in_da,
    input  logic              in_rw,
    input  logic              in_mb,
    input  logic [DATA_W-1:0] in_imm,
    output logic [ADDR_W-1:0] rf_aa,
    output logic [ADDR_W-1:0] rf_ba,
    input  logic [DATA_W-1:0] rf_a_data,
    input  logic [DATA_W-1:0] rf_b_data,
    input  logic              wb_rw,
    input  logic [ADDR_W-1:0] wb_da,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [ADDR_W-1:0] out_da,
    output logic              out_rw
);

    operand_entry_t    entry_q, entry_d;
    logic              valid_q, valid_d;
    logic              capture;
    logic              hazard;
    logic [DATA_W-1:0] cap_a, cap_b_reg;
    logic [DATA_W-1:0] ref_a, ref_b;

    assign rf_aa = in_aa;
    assign rf_ba = in_ba;

`ifdef OPERAND_BYPASS_EN
    operand_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_cap_a (
        .addr_i(in_aa), .rf_data_i(rf_a_data), .wb_rw_i(wb_rw),
        .wb_da_i(wb_da), .wb_data_i(wb_data), .data_o(cap_a)
    );
    operand_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_cap_b (
        .addr_i(in_ba), .rf_data_i(rf_b_data), .wb_rw_i(wb_rw),
        .wb_da_i(wb_da), .wb_data_i(wb_data), .data_o(cap_b_reg)
    );
    assign hazard = 1'b0;
`else
    // Raw capture; a same-cycle write to a used source holds the instruction
    // one cycle until the register file shows the new value.
    assign cap_a     = rf_a_data;
    assign cap_b_reg = rf_b_data;
    assign hazard    = wb_rw && ((wb_da == in_aa) || (!in_mb && (wb_da == in_ba)));
`endif

    // Refresh of a stalled entry; B only tracks a register when mb=0.
    operand_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ref_a (
        .addr_i(entry_q.aa), .rf_data_i(entry_q.a), .wb_rw_i(wb_rw),
        .wb_da_i(wb_da), .wb_data_i(wb_data), .data_o(ref_a)
    );
    operand_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ref_b (
        .addr_i(entry_q.ba), .rf_data_i(entry_q.b), .wb_rw_i(wb_rw && !entry_q.mb),
        .wb_da_i(wb_da), .wb_data_i(wb_data), .data_o(ref_b)
    );

    assign in_ready = (!valid_q || out_ready) && !hazard;
    assign capture  = in_valid && in_ready && !flush;

    // Next entry: flush > capture > pop > refresh while stalled.
    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d    = 1'b1;
            entry_d.a  = cap_a;
            entry_d.b  = in_mb ? in_imm : cap_b_reg;
            entry_d.da = in_da;
            entry_d.rw = in_rw;
            entry_d.aa = in_aa;
            entry_d.ba = in_ba;
            entry_d.mb = in_mb;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            entry_d.a = ref_a;
            entry_d.b = ref_b;
        end
    end

    // Entry register; reset drops everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign out_valid = valid_q;
    assign out_a     = entry_q.a;
    assign out_b     = entry_q.b;
    assign out_da    = entry_q.da;
    assign out_rw    = entry_q.rw;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage with a behavioural 32x32 register
// file whose writes become readable one cycle later.
module tb_operand_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready;
    logic [4:0]  in_aa, in_ba, in_da, rf_aa, rf_ba, wb_da, out_da;
    logic        in_rw, in_mb, wb_rw, out_valid, out_ready, out_rw;
    logic [31:0] in_imm, rf_a_data, rf_b_data, wb_data, out_a, out_b;
    logic [31:0] rf_mem [32];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    operand_fetch_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_aa(in_aa), .in_ba(in_ba), .in_da(in_da), .in_rw(in_rw),
        .in_mb(in_mb), .in_imm(in_imm),
        .rf_aa(rf_aa), .rf_ba(rf_ba), .rf_a_data(rf_a_data), .rf_b_data(rf_b_data),
        .wb_rw(wb_rw), .wb_da(wb_da), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_da(out_da), .out_rw(out_rw)
    );

    // Register file: r[n]=n after reset, writes visible after the edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= i;
        end else if (wb_rw) begin
            rf_mem[wb_da] <= wb_data;
        end
    end
    assign rf_a_data = rf_mem[rf_aa];
    assign rf_b_data = rf_mem[rf_ba];

    task automatic set_in(input logic v, input logic [4:0] aa, input logic [4:0] ba,
                          input logic [4:0] da, input logic rw, input logic mb,
                          input logic [31:0] imm);
        in_valid = v; in_aa = aa; in_ba = ba; in_da = da;
        in_rw = rw; in_mb = mb; in_imm = imm;
    endtask

    task automatic set_wb(input logic rw, input logic [4:0] da, input logic [31:0] d);
        wb_rw = rw; wb_da = da; wb_data = d;
    endtask

    task automatic test_reset;
        #12;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %0b want 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got %0b want 1", in_ready); end
        reset = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        set_in(1'b1, 5'd3, 5'd7, 5'd1, 1'b1, 1'b0, 32'h0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL pre_rst_valid got %0b want 1", out_valid); end
        #2 reset = 1'b1;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid got %0b want 0", out_valid); end
        tests++; if (out_a !== 32'h0) begin fails++; $display("FAIL midrst_a got %h want 0", out_a); end
        tests++; if (out_b !== 32'h0) begin fails++; $display("FAIL midrst_b got %h want 0", out_b); end
        tests++; if (out_da !== 5'd0 || out_rw !== 1'b0) begin fails++; $display("FAIL midrst_da got %0d/%0b want 0/0", out_da, out_rw); end
        #1 reset = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_rst_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_plain_read;
        out_ready = 1'b1;
        @(posedge clk); #1;
        set_in(1'b1, 5'd3, 5'd7, 5'd4, 1'b1, 1'b0, 32'h0);
        tests++; if (rf_aa !== 5'd3 || rf_ba !== 5'd7) begin fails++; $display("FAIL rf_addr got %0d/%0d want 3/7", rf_aa, rf_ba); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL plain_valid got %0b want 1", out_valid); end
        tests++; if (out_a !== 32'd3) begin fails++; $display("FAIL plain_a got %h want 3", out_a); end
        tests++; if (out_b !== 32'd7) begin fails++; $display("FAIL plain_b got %h want 7", out_b); end
        tests++; if (out_da !== 5'd4 || out_rw !== 1'b1) begin fails++; $display("FAIL plain_da got %0d/%0b want 4/1", out_da, out_rw); end
    endtask

    task automatic test_bypass;
        @(posedge clk); #1;
        set_in(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 32'h0);
        set_wb(1'b1, 5'd5, 32'hDEADBEEF);
        #1;
`ifdef OPERAND_BYPASS_EN
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL byp_ready got %0b want 1", in_ready); end
        @(posedge clk); #1;
        set_wb(1'b0, 5'd0, 32'h0);
        in_valid = 1'b0;
`else
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL byp_stall got %0b want 0", in_ready); end
        @(posedge clk); #1;
        set_wb(1'b0, 5'd0, 32'h0);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL byp_stall_valid got %0b want 0", out_valid); end
        @(posedge clk); #1;
        in_valid = 1'b0;
`endif
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL byp_valid got %0b want 1", out_valid); end
        tests++; if (out_a !== 32'hDEADBEEF) begin fails++; $display("FAIL byp_a got %h want deadbeef", out_a); end
        tests++; if (out_b !== 32'h0) begin fails++; $display("FAIL byp_b got %h want 0", out_b); end
    endtask

    task automatic test_immediate;
        @(posedge clk); #1;
        set_in(1'b1, 5'd1, 5'd5, 5'd2, 1'b0, 1'b1, 32'h1234);
        set_wb(1'b1, 5'd5, 32'h55);
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL imm_ready got %0b want 1", in_ready); end
        @(posedge clk); #1;
        set_wb(1'b0, 5'd0, 32'h0);
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL imm_valid got %0b want 1", out_valid); end
        tests++; if (out_b !== 32'h1234) begin fails++; $display("FAIL imm_b got %h want 1234", out_b); end
        tests++; if (out_a !== 32'd1) begin fails++; $display("FAIL imm_a got %h want 1", out_a); end
    endtask

    task automatic test_refresh;
        @(posedge clk); #1;
        out_ready = 1'b0;
        set_in(1'b1, 5'd9, 5'd9, 5'd2, 1'b1, 1'b0, 32'h0);
        @(posedge clk); #1;
        set_in(1'b1, 5'd1, 5'd1, 5'd3, 1'b0, 1'b0, 32'h0);
        tests++; if (out_a !== 32'd9 || out_b !== 32'd9) begin fails++; $display("FAIL ref_pre got %h/%h want 9/9", out_a, out_b); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL ref_ready got %0b want 0", in_ready); end
        set_wb(1'b1, 5'd9, 32'hA5A5A5A5);
        @(posedge clk); #1;
        set_wb(1'b0, 5'd0, 32'h0);
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL ref_valid got %0b want 1", out_valid); end
        tests++; if (out_a !== 32'hA5A5A5A5) begin fails++; $display("FAIL ref_a got %h want a5a5a5a5", out_a); end
        tests++; if (out_b !== 32'hA5A5A5A5) begin fails++; $display("FAIL ref_b got %h want a5a5a5a5", out_b); end
        tests++; if (out_da !== 5'd2) begin fails++; $display("FAIL ref_da got %0d want 2", out_da); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL ref_hold_ready got %0b want 0", in_ready); end
    endtask

    task automatic test_flush;
        out_ready = 1'b1;
        flush = 1'b1;
        set_in(1'b1, 5'd3, 5'd7, 5'd8, 1'b1, 1'b0, 32'h0);
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL fl_ready got %0b want 1", in_ready); end
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fl_valid got %0b want 0", out_valid); end
        @(posedge clk); #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fl_nocap got %0b want 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_a [3];
        exp_a[0] = 32'd1; exp_a[1] = 32'd2; exp_a[2] = 32'd3;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 5'(i + 1), 5'(i + 10), 5'd0, 1'b0, 1'b0, 32'h0);
            @(posedge clk); #1;
            tests++;
            if (out_valid !== 1'b1 || out_a !== exp_a[i] || out_b !== 32'(i + 10)) begin
                fails++;
                $display("FAIL b2b_%0d got v=%0b a=%h b=%h want v=1 a=%h b=%h",
                         i, out_valid, out_a, out_b, exp_a[i], 32'(i + 10));
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL pop_only got %0b want 0", out_valid); end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
        set_wb(1'b0, 5'd0, 32'h0);
        test_reset;
        test_plain_read;
        test_bypass;
        test_immediate;
        test_refresh;
        test_flush;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
